// File: rtl/jump_resolve_unit.sv
// Resolves jumps and branches in decode; registers redirect/link/squash and tracks the delay shadow slot.
// Optional performance counters are built when JRU_PERF_CNT_EN is defined.
module jump_resolve_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_valid,
  input  logic              in_stall,
  input  logic              in_special,
  input  logic [5:0]        in_instruction,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [15:0]       in_imm16,
  input  logic [25:0]       in_target26,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  output logic              out_redirect,
  output logic [ADDR_W-1:0] out_target,
  output logic              out_link,
  output logic [ADDR_W-1:0] out_link_addr,
  output logic              out_squash,
  output logic [CNT_W-1:0]  out_cnt_uncond,
  output logic [CNT_W-1:0]  out_cnt_cond,
  output logic [CNT_W-1:0]  out_cnt_taken
);

  typedef enum logic {RUN, SHADOW} state_t;
  state_t state;

  logic [ADDR_W-1:0] pc_plus4, pc_plus8, branch_target, jump_target, reg_target, target_next;
  logic is_uncond, is_cond, is_link, take;
  logic signed [DATA_W-1:0] rs_s;

  assign pc_plus4      = in_pc + ADDR_W'(4);
  assign pc_plus8      = in_pc + ADDR_W'(8);
  assign branch_target = pc_plus4 + {{(ADDR_W-18){in_imm16[15]}}, in_imm16, 2'b00};
  assign rs_s          = $signed(in_rs_data);

  // Region bits of the jump target come from the delay-slot PC; absent for a 28-bit PC.
  generate
    if (ADDR_W > 28) begin : g_jump_region
      assign jump_target = {pc_plus4[ADDR_W-1:28], in_target26, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {in_target26, 2'b00};
    end
    if (ADDR_W > DATA_W) begin : g_reg_zext
      assign reg_target = {{(ADDR_W-DATA_W){1'b0}}, in_rs_data};
    end else begin : g_reg_trunc
      assign reg_target = in_rs_data[ADDR_W-1:0];
    end
  endgenerate

  always_comb begin
    is_uncond   = 1'b0;
    is_cond     = 1'b0;
    is_link     = 1'b0;
    take        = 1'b0;
    target_next = branch_target;
    if (in_special) begin
      case (in_instruction)
        6'b001000: begin is_uncond = 1'b1; take = 1'b1; target_next = reg_target; end
        6'b001001: begin is_uncond = 1'b1; take = 1'b1; is_link = 1'b1; target_next = reg_target; end
        default: ;
      endcase
    end else begin
      case (in_instruction)
        6'b000010: begin is_uncond = 1'b1; take = 1'b1; target_next = jump_target; end
        6'b000011: begin is_uncond = 1'b1; take = 1'b1; is_link = 1'b1; target_next = jump_target; end
        6'b000100: begin is_cond = 1'b1; take = (in_rs_data == in_rt_data); end
        6'b000101: begin is_cond = 1'b1; take = (in_rs_data != in_rt_data); end
        6'b000110: begin is_cond = 1'b1; take = (rs_s <= 0); end
        6'b000111: begin is_cond = 1'b1; take = (rs_s > 0); end
        6'b000001: begin is_cond = 1'b1; take = (rs_s >= 0); end
        default: ;
      endcase
    end
  end

  logic accept;
  assign accept = in_valid && !in_stall && (state == RUN);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state         <= RUN;
      out_redirect  <= 1'b0;
      out_link      <= 1'b0;
      out_squash    <= 1'b0;
      out_target    <= '0;
      out_link_addr <= '0;
    end else begin
      out_redirect <= 1'b0;
      out_link     <= 1'b0;
      out_squash   <= 1'b0;
      if (in_valid && !in_stall) begin
        if (state == SHADOW) begin
          out_squash <= 1'b1;
          state      <= RUN;
        end else if (take) begin
          out_redirect <= 1'b1;
          out_target   <= target_next;
          state        <= SHADOW;
          if (is_link) begin
            out_link      <= 1'b1;
            out_link_addr <= pc_plus8;
          end
        end
      end
    end
  end

`ifdef JRU_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_uncond_reg, cnt_cond_reg, cnt_taken_reg;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cnt_uncond_reg <= '0;
      cnt_cond_reg   <= '0;
      cnt_taken_reg  <= '0;
    end else if (accept) begin
      if (is_uncond && cnt_uncond_reg != '1) cnt_uncond_reg <= cnt_uncond_reg + 1'b1;
      if (is_cond && cnt_cond_reg != '1) cnt_cond_reg <= cnt_cond_reg + 1'b1;
      if (is_cond && take && cnt_taken_reg != '1) cnt_taken_reg <= cnt_taken_reg + 1'b1;
    end
  end

  assign out_cnt_uncond = cnt_uncond_reg;
  assign out_cnt_cond   = cnt_cond_reg;
  assign out_cnt_taken  = cnt_taken_reg;
`else
  logic unused_cnt_sig;
  assign unused_cnt_sig = accept | is_uncond | is_cond;
  assign out_cnt_uncond = '0;
  assign out_cnt_cond   = '0;
  assign out_cnt_taken  = '0;
`endif

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Directed bench for jump_resolve_unit (CNT_W=4); counter expectations follow JRU_PERF_CNT_EN.
module tb_jump_resolve_unit;

  logic        in_clk = 1'b0;
  logic        in_rst, in_valid, in_stall, in_special;
  logic [5:0]  in_instruction;
  logic [31:0] in_pc, in_rs_data, in_rt_data;
  logic [15:0] in_imm16;
  logic [25:0] in_target26;
  logic        out_redirect, out_link, out_squash;
  logic [31:0] out_target, out_link_addr;
  logic [3:0]  out_cnt_uncond, out_cnt_cond, out_cnt_taken;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_BLEZ = 6'b000110, OP_BGTZ = 6'b000111,
                         OP_BGEZ = 6'b000001, FN_JR = 6'b001000, FN_JALR = 6'b001001,
                         OP_LW = 6'b100011, FN_ADD = 6'b100000;

  jump_resolve_unit #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_stall(in_stall),
    .in_special(in_special), .in_instruction(in_instruction), .in_pc(in_pc),
    .in_imm16(in_imm16), .in_target26(in_target26), .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data), .out_redirect(out_redirect), .out_target(out_target),
    .out_link(out_link), .out_link_addr(out_link_addr), .out_squash(out_squash),
    .out_cnt_uncond(out_cnt_uncond), .out_cnt_cond(out_cnt_cond), .out_cnt_taken(out_cnt_taken)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [3:0] cnt(input int n);
`ifdef JRU_PERF_CNT_EN
    return n[3:0];
`else
    return 4'd0;
`endif
  endfunction

  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask

  task automatic set_instr(input logic valid, input logic special, input logic [5:0] code,
                           input logic [31:0] pc, input logic [15:0] imm,
                           input logic [25:0] t26, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = valid; in_special = special; in_instruction = code; in_pc = pc;
    in_imm16 = imm; in_target26 = t26; in_rs_data = rs; in_rt_data = rt;
  endtask

  task automatic nop_slot;
    set_instr(1'b1, 1'b0, OP_LW, 32'h0000_0900, 16'h0, 26'h0, 32'h0, 32'h0);
  endtask

  initial begin
    in_rst = 1'b1; in_stall = 1'b0;
    set_instr(1'b0, 1'b0, 6'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
    tick; tick;
    check("rst_redirect", out_redirect, 0);
    check("rst_link", out_link, 0);
    check("rst_squash", out_squash, 0);
    check("rst_target", out_target, 0);
    check("rst_link_addr", out_link_addr, 0);
    check("rst_cnt_uncond", out_cnt_uncond, 0);
    in_rst = 1'b0;

    // BEQ taken backwards by one word onto itself
    set_instr(1'b1, 1'b0, OP_BEQ, 32'h0000_0100, 16'hFFFF, 26'h0, 32'd5, 32'd5);
    tick;
    check("beq_redirect", out_redirect, 1);
    check("beq_target", out_target, 32'h0000_0100);
    check("beq_link", out_link, 0);
    check("beq_cnt_cond", out_cnt_cond, cnt(1));
    check("beq_cnt_taken", out_cnt_taken, cnt(1));
    nop_slot; tick;
    check("beq_squash", out_squash, 1);
    check("beq_slot_redirect", out_redirect, 0);

    // JAL within the 256MB region
    set_instr(1'b1, 1'b0, OP_JAL, 32'h1000_0010, 16'h0, 26'h0000040, 32'h0, 32'h0);
    tick;
    check("jal_redirect", out_redirect, 1);
    check("jal_target", out_target, 32'h1000_0100);
    check("jal_link", out_link, 1);
    check("jal_link_addr", out_link_addr, 32'h1000_0018);
    check("jal_cnt_uncond", out_cnt_uncond, cnt(1));
    nop_slot; tick;
    check("jal_squash", out_squash, 1);
    check("jal_link_pulse", out_link, 0);
    check("jal_target_hold", out_target, 32'h1000_0100);

    // BGTZ on most-negative value: not taken, no shadow
    set_instr(1'b1, 1'b0, OP_BGTZ, 32'h0000_0200, 16'h0004, 26'h0, 32'h8000_0000, 32'h0);
    tick;
    check("bgtz_redirect", out_redirect, 0);
    check("bgtz_target_hold", out_target, 32'h1000_0100);
    check("bgtz_cnt_cond", out_cnt_cond, cnt(2));
    check("bgtz_cnt_taken", out_cnt_taken, cnt(1));
    nop_slot; tick;
    check("bgtz_no_squash", out_squash, 0);

    set_instr(1'b1, 1'b0, OP_BNE, 32'h0000_0400, 16'h0010, 26'h0, 32'd1, 32'd2);
    tick;
    check("bne_redirect", out_redirect, 1);
    check("bne_target", out_target, 32'h0000_0444);
    check("bne_cnt_taken", out_cnt_taken, cnt(2));
    nop_slot; tick;
    check("bne_squash", out_squash, 1);

    // BLEZ at zero, then a stalled shadow slot
    set_instr(1'b1, 1'b0, OP_BLEZ, 32'h0000_0500, 16'hFFFE, 26'h0, 32'h0, 32'h0);
    tick;
    check("blez_redirect", out_redirect, 1);
    check("blez_target", out_target, 32'h0000_04FC);
    nop_slot; in_stall = 1'b1; tick;
    check("blez_stall_squash", out_squash, 0);
    check("blez_stall_pulse", out_redirect, 0);
    in_stall = 1'b0; tick;
    check("blez_squash", out_squash, 1);

    set_instr(1'b1, 1'b0, OP_BGEZ, 32'h0000_0600, 16'h0008, 26'h0, 32'hFFFF_FFFF, 32'h0);
    tick;
    check("bgez_redirect", out_redirect, 0);
    check("bgez_cnt_cond", out_cnt_cond, cnt(5));
    check("bgez_cnt_taken", out_cnt_taken, cnt(3));

    // Codes matching control encodings in the other decode space do nothing
    set_instr(1'b1, 1'b1, FN_ADD, 32'h0000_0700, 16'h0, 26'h0, 32'h1234, 32'h1234);
    tick;
    check("add_redirect", out_redirect, 0);
    set_instr(1'b1, 1'b0, FN_JR, 32'h0000_0704, 16'h0, 26'h0, 32'h1234, 32'h0);
    tick;
    check("addi_redirect", out_redirect, 0);
    check("addi_cnt_uncond", out_cnt_uncond, cnt(1));

    // JR held by stall for three cycles
    set_instr(1'b1, 1'b1, FN_JR, 32'h0000_0800, 16'h0, 26'h0, 32'h0040_0020, 32'h0);
    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("jr_stalled", out_redirect, 0);
    end
    in_stall = 1'b0; tick;
    check("jr_redirect", out_redirect, 1);
    check("jr_target", out_target, 32'h0040_0020);
    check("jr_link", out_link, 0);
    in_valid = 1'b0; tick;
    check("jr_single_pulse", out_redirect, 0);
    check("jr_cnt_uncond", out_cnt_uncond, cnt(2));
    nop_slot; tick;
    check("jr_squash", out_squash, 1);

    set_instr(1'b1, 1'b1, FN_JALR, 32'h0000_0300, 16'h0, 26'h0, 32'h0000_1234, 32'h0);
    tick;
    check("jalr_target", out_target, 32'h0000_1234);
    check("jalr_link", out_link, 1);
    check("jalr_link_addr", out_link_addr, 32'h0000_0308);
    nop_slot; tick;
    check("jalr_squash", out_squash, 1);

    // Control instruction inside the shadow is squashed, not executed
    set_instr(1'b1, 1'b0, OP_J, 32'h0000_0000, 16'h0, 26'h1, 32'h0, 32'h0);
    tick;
    check("j1_target", out_target, 32'h0000_0004);
    check("j1_cnt_uncond", out_cnt_uncond, cnt(4));
    set_instr(1'b1, 1'b0, OP_J, 32'h0000_0004, 16'h0, 26'h2, 32'h0, 32'h0);
    tick;
    check("jshadow_squash", out_squash, 1);
    check("jshadow_redirect", out_redirect, 0);
    check("jshadow_target", out_target, 32'h0000_0004);
    check("jshadow_cnt_uncond", out_cnt_uncond, cnt(4));
    set_instr(1'b1, 1'b0, OP_J, 32'h0000_0008, 16'h0, 26'h3, 32'h0, 32'h0);
    tick;
    check("j3_target", out_target, 32'h0000_000C);

    // Reset while a shadow slot is pending
    in_rst = 1'b1;
    set_instr(1'b1, 1'b0, OP_J, 32'h0000_000C, 16'h0, 26'h4, 32'h0, 32'h0);
    tick;
    check("rst2_redirect", out_redirect, 0);
    check("rst2_squash", out_squash, 0);
    check("rst2_target", out_target, 0);
    check("rst2_link_addr", out_link_addr, 0);
    check("rst2_cnt_uncond", out_cnt_uncond, 0);
    in_rst = 1'b0;
    set_instr(1'b1, 1'b0, OP_J, 32'h0000_0010, 16'h0, 26'h5, 32'h0, 32'h0);
    tick;
    check("post_rst_redirect", out_redirect, 1);
    check("post_rst_target", out_target, 32'h0000_0014);
    nop_slot; tick;

    // Saturation: 19 more jumps, each followed by its squash slot
    for (int i = 0; i < 19; i++) begin
      set_instr(1'b1, 1'b0, OP_J, 32'h0000_0020, 16'h0, 26'h10, 32'h0, 32'h0);
      tick;
      nop_slot; tick;
    end
    check("sat_cnt_uncond", out_cnt_uncond, cnt(15));
    check("sat_cnt_cond", out_cnt_cond, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/jump_resolve_unit.md
JUMP_RESOLVE_UNIT -- requirements
Module: jump_resolve_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning; ADDR_W, 32, PC width, legal 28..32.
REQ-002 DATA_W, 32, register operand width; CNT_W, 16, performance counter width.
REQ-003 Ports, one per line: name direction width meaning; in_clk input 1 sole clock, rising edge.
REQ-004 in_rst input 1 reset, synchronous, active-high.
REQ-005 in_valid input 1 decode-stage instruction present; in_stall input 1 pipeline hold.
REQ-006 in_special input 1 R-type flag; in_instruction input 6 funct if in_special=1, else opcode.
REQ-007 in_pc input ADDR_W instruction PC; in_imm16 input 16 branch offset; in_target26 input 26 jump index.
REQ-008 in_rs_data / in_rt_data input DATA_W register operands.
REQ-009 out_redirect output 1 taken control transfer; out_target output ADDR_W new PC.
REQ-010 out_link output 1 link write request; out_link_addr output ADDR_W value in_pc+8.
REQ-011 out_squash output 1 current in_valid instruction discarded (shadow slot).
REQ-012 out_cnt_uncond / out_cnt_cond / out_cnt_taken output CNT_W each, performance counters.

Function
REQ-013 Decode (in_special=0): 000010 J, 000011 JAL, 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ, 000001 BGEZ (rt field ignored); in_special=1: 001000 JR, 001001 JALR; all other codes non-control, no effect.
REQ-014 Conditions signed on DATA_W: BEQ rs==rt, BNE rs!=rt, BLEZ rs<=0, BGTZ rs>0, BGEZ rs>=0; J/JAL/JR/JALR always taken.
REQ-015 Branch target = in_pc+4+(sign_ext(in_imm16)<<2), modulo 2^ADDR_W.
REQ-016 J/JAL target = {(in_pc+4)[ADDR_W-1:28], in_target26, 2'b00}; upper field empty when ADDR_W=28.
REQ-017 JR/JALR target = in_rs_data[ADDR_W-1:0], zero-extended when ADDR_W>DATA_W.
REQ-018 Accepted instruction: in_valid=1, in_stall=0, state RUN; all outputs registered, valid exactly 1 cycle after acceptance.
REQ-019 out_redirect, out_link pulse 1 cycle per accepted taken/linking instruction; out_target, out_link_addr hold last value otherwise.
REQ-020 JAL, JALR assert out_link with out_link_addr=in_pc+8.
REQ-021 FSM states RUN, SHADOW; RUN->SHADOW on accepted taken instruction; SHADOW->RUN when in_valid=1 and in_stall=0.
REQ-022 In SHADOW the next in_valid instruction with in_stall=0 produces out_squash=1 for 1 cycle, no redirect, no link, no counting, even if it is itself a control instruction.
REQ-023 in_stall=1 freezes state, counters, and output registers (pulses deassert, no new pulses).
REQ-024 Not-taken branch: no redirect, no state change; counted per REQ-027.

Reset
REQ-025 On in_rst=1 at a rising edge: state RUN, out_redirect=0, out_link=0, out_squash=0, out_target=0, out_link_addr=0, all counters 0.
REQ-026 in_rst dominates in_valid and in_stall in the same cycle; a pending shadow slot is abandoned.

Configuration
REQ-027 Macro JRU_PERF_CNT_EN defined: out_cnt_uncond +1 per accepted J/JAL/JR/JALR, out_cnt_cond +1 per accepted conditional branch, out_cnt_taken +1 per taken conditional; all saturate at 2^CNT_W-1.
REQ-028 JRU_PERF_CNT_EN undefined: counter registers absent, three counter outputs tied to 0; all other behaviour identical.

Verification
REQ-029 BEQ, pc=0x00000100, imm16=0xFFFF, rs=rt=5 -> next cycle out_redirect=1, out_target=0x00000100; following valid instruction -> out_squash=1.
REQ-030 JAL, pc=0x10000010, target26=0x0000040 -> out_target=0x10000100, out_link=1, out_link_addr=0x10000018.
REQ-031 BGTZ rs=0x80000000 -> no redirect; next instruction not squashed; out_cnt_cond +1, out_cnt_taken unchanged.
REQ-032 JR rs=0x00400020 with in_stall=1 for 3 cycles then 0 -> single out_redirect pulse one cycle after stall release, target 0x00400020.
REQ-033 In SHADOW, J arrives -> out_squash=1, no redirect, counters unchanged; in_rst asserted in SHADOW -> state RUN, all outputs 0.
REQ-034 CNT_W=4, 20 accepted J instructions with intervening squash slots -> out_cnt_uncond=15 (saturated) with macro defined; 0 without.
